// File: rtl/fill_arb_pkg.sv
// Shared types and sizing for the cache fill arbiter.
package fill_arb_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int FILL_WORDS = 8;
    localparam int MEM_LAT    = 4;
    localparam int WORD_W     = $clog2(FILL_WORDS);
    localparam int BASE_W     = ADDR_W - WORD_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FILL_D = 2'd2,
        FILL_I = 2'd3
    } state_e;

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Cache-side request, shared-memory and data/tag-array write signals of the fill arbiter.
interface cache_fill_arbiter_if;
    import fill_arb_pkg::*;

    logic              icache_miss;
    logic [ADDR_W-1:0] icache_addr;
    logic              dcache_miss;
    logic [ADDR_W-1:0] dcache_addr;
    logic              dcache_wr;
    logic [ADDR_W-1:0] dcache_wr_addr;
    logic [DATA_W-1:0] dcache_wdata;

    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] fill_data;
    logic [WORD_W-1:0] fill_word;
    logic              fill_we_i;
    logic              fill_we_d;
    logic              tag_we_i;
    logic              tag_we_d;
    logic              wr_ack;
    logic              stall;

    modport slave (
        input  icache_miss, icache_addr, dcache_miss, dcache_addr,
        input  dcache_wr, dcache_wr_addr, dcache_wdata,
        input  mem_data_valid, mem_rdata,
        output mem_enable, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, fill_we_i, fill_we_d,
        output tag_we_i, tag_we_d, wr_ack, stall
    );

    modport master (
        output icache_miss, icache_addr, dcache_miss, dcache_addr,
        output dcache_wr, dcache_wr_addr, dcache_wdata,
        output mem_data_valid, mem_rdata,
        input  mem_enable, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, fill_we_i, fill_we_d,
        input  tag_we_i, tag_we_d, wr_ack, stall
    );

endinterface

// File: rtl/cache_fill_arbiter_fill_ctr.sv
// Issue and return word counters for one line fill; cleared whenever no fill is active.
module fill_ctr
    import fill_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              issue_i,
    input  logic              ret_i,
    output logic [WORD_W-1:0] issue_cnt_o,
    output logic [WORD_W-1:0] ret_cnt_o,
    output logic              issue_done_o,
    output logic              ret_done_o
);

    localparam logic [WORD_W-1:0] LAST = WORD_W'(FILL_WORDS - 1);

    logic [WORD_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [WORD_W-1:0] ret_cnt_q, ret_cnt_d;
    logic              issue_done_q, issue_done_d;

    always_comb begin
        issue_cnt_d  = issue_cnt_q;
        issue_done_d = issue_done_q;
        ret_cnt_d    = ret_cnt_q;
        if (clr_i) begin
            issue_cnt_d  = '0;
            issue_done_d = 1'b0;
            ret_cnt_d    = '0;
        end else begin
            // Issue count parks on the last word so a ninth read can never go out.
            if (issue_i && !issue_done_q) begin
                if (issue_cnt_q == LAST) issue_done_d = 1'b1;
                else                     issue_cnt_d  = issue_cnt_q + 1'b1;
            end
            if (ret_i) ret_cnt_d = ret_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q  <= '0;
            issue_done_q <= 1'b0;
            ret_cnt_q    <= '0;
        end else begin
            issue_cnt_q  <= issue_cnt_d;
            issue_done_q <= issue_done_d;
            ret_cnt_q    <= ret_cnt_d;
        end
    end

    assign issue_cnt_o  = issue_cnt_q;
    assign ret_cnt_o    = ret_cnt_q;
    assign issue_done_o = issue_done_q;
    assign ret_done_o   = ret_i && (ret_cnt_q == LAST);

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D line fills and D write-through stores onto one memory port.
// Define FILL_ARB_RR_EN for round-robin I/D miss arbitration (default: D over I).
module cache_fill_arbiter
    import fill_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    cache_fill_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic              in_fill, issue, ret, grant_d;
    logic [WORD_W-1:0] issue_cnt, ret_cnt;
    logic              issue_done, ret_done;

    assign in_fill = (state_q == FILL_D) || (state_q == FILL_I);
    assign issue   = in_fill && !issue_done;
    assign ret     = in_fill && bus.mem_data_valid;

    fill_ctr u_fill_ctr (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (!in_fill),
        .issue_i      (issue),
        .ret_i        (ret),
        .issue_cnt_o  (issue_cnt),
        .ret_cnt_o    (ret_cnt),
        .issue_done_o (issue_done),
        .ret_done_o   (ret_done)
    );

`ifdef FILL_ARB_RR_EN
    logic last_i_q, last_i_d;

    // Reset as if I was granted last so the first tie goes to D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_i_q <= 1'b1;
        else        last_i_q <= last_i_d;
    end

    assign grant_d  = bus.dcache_miss && (!bus.icache_miss || last_i_q);
    assign last_i_d = (state_q == IDLE && !bus.dcache_wr && (bus.dcache_miss || bus.icache_miss))
                      ? !grant_d : last_i_q;
`else
    assign grant_d = bus.dcache_miss;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        base_d             = base_q;
        bus.mem_enable     = 1'b0;
        bus.mem_wr         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wdata      = '0;
        bus.fill_data      = '0;
        bus.fill_word      = '0;
        bus.fill_we_i      = 1'b0;
        bus.fill_we_d      = 1'b0;
        bus.tag_we_i       = 1'b0;
        bus.tag_we_d       = 1'b0;
        bus.wr_ack         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.dcache_wr) begin
                    state_d = WRITE;
                end else if (grant_d) begin
                    state_d = FILL_D;
                    base_d  = bus.dcache_addr[ADDR_W-1:WORD_W+1];
                end else if (bus.icache_miss) begin
                    state_d = FILL_I;
                    base_d  = bus.icache_addr[ADDR_W-1:WORD_W+1];
                end
            end
            WRITE: begin
                bus.mem_enable = 1'b1;
                bus.mem_wr     = 1'b1;
                bus.mem_addr   = bus.dcache_wr_addr;
                bus.mem_wdata  = bus.dcache_wdata;
                bus.wr_ack     = 1'b1;
                state_d        = IDLE;
            end
            FILL_D, FILL_I: begin
                if (issue) begin
                    bus.mem_enable = 1'b1;
                    bus.mem_addr   = {base_q, issue_cnt, 1'b0};
                end
                if (ret) begin
                    bus.fill_data = bus.mem_rdata;
                    bus.fill_word = ret_cnt;
                    bus.fill_we_d = (state_q == FILL_D);
                    bus.fill_we_i = (state_q == FILL_I);
                end
                bus.tag_we_d = ret_done && (state_q == FILL_D);
                bus.tag_we_i = ret_done && (state_q == FILL_I);
                if (ret_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also masks the miss-driven term so every output reads 0 while rst_n is low.
    assign bus.stall = rst_n && ((state_q != IDLE) || bus.icache_miss || bus.dcache_miss);

endmodule
